// File: rtl/vga_game_pkg.sv
// Shared types and constants for the VGA game object/collision logic.
package vga_game_pkg;

    // HitEdgeCode bit order: {Left, Top, Right, Bottom}
    typedef logic [3:0] hit_edge_t;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        PENDING  = 2'd1,
        COOLDOWN = 2'd2
    } collector_state_t;

    localparam int SCREEN_PIXELS = 640 * 480;

    localparam hit_edge_t EDGE_LEFT   = 4'b1000;
    localparam hit_edge_t EDGE_TOP    = 4'b0100;
    localparam hit_edge_t EDGE_RIGHT  = 4'b0010;
    localparam hit_edge_t EDGE_BOTTOM = 4'b0001;

endpackage

// File: rtl/frame_overlap_accumulator.sv
// Per-frame player/syringe overlap counter and edge-code OR.
// At startOfFrame the finished frame is presented on snap_* (the pre-update
// accumulator values) and the accumulators restart with that cycle's pixel,
// so the startOfFrame pixel belongs to the new frame.
module frame_overlap_accumulator
    import vga_game_pkg::*;
#(
    parameter int COUNT_W = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               ov,
    input  logic [3:0]         syringeEdge,
    output logic [COUNT_W-1:0] snap_cnt,
    output logic [3:0]         snap_edge,
    output logic               snap_strobe
);

    logic [COUNT_W-1:0] acc_cnt;
    hit_edge_t          acc_edge;

    // Accumulate overlap pixels; restart on each frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt  <= '0;
            acc_edge <= '0;
        end else if (startOfFrame) begin
            acc_cnt  <= COUNT_W'(ov);
            acc_edge <= ov ? syringeEdge : '0;
        end else if (ov) begin
            if (acc_cnt != '1)
                acc_cnt <= acc_cnt + COUNT_W'(1);
            acc_edge <= acc_edge | syringeEdge;
        end
    end

    // Snapshot is the value held going into the boundary cycle.
    assign snap_cnt    = acc_cnt;
    assign snap_edge   = acc_edge;
    assign snap_strobe = startOfFrame;

endmodule

// File: rtl/syringe_hit_collector.sv
// Collects player/syringe overlap per frame and reports at most one hit
// event per frame over a valid/ack handshake, followed by a cooldown of
// COOLDOWN_FRAMES frames. All outputs are registered.
module syringe_hit_collector
    import vga_game_pkg::*;
#(
    parameter int MIN_OVERLAP     = 4,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int COUNT_W         = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               playerDR,
    input  logic               syringeDR,
    input  logic [3:0]         syringeEdge,
    output logic               hit_valid,
    output logic [3:0]         hit_edge,
    output logic [COUNT_W-1:0] hit_count,
    input  logic               hit_ack,
    output logic [7:0]         missed_hits,
    output logic               cooldown_active
);

    // +2 keeps the width at least 1 even when COOLDOWN_FRAMES is 0.
    localparam int             CD_W    = $clog2(COOLDOWN_FRAMES + 2);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

    collector_state_t   state_q, state_d;
    logic [CD_W-1:0]    cd_q, cd_d;
    logic               valid_d;
    hit_edge_t          edge_d;
    logic [COUNT_W-1:0] count_d;
    logic [7:0]         missed_d;

    logic               ov;
    logic [COUNT_W-1:0] snap_cnt;
    hit_edge_t          snap_edge;
    logic               snap_strobe;
    logic               qualify;

    assign ov = playerDR & syringeDR;

    frame_overlap_accumulator #(
        .COUNT_W (COUNT_W)
    ) u_acc (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .ov           (ov),
        .syringeEdge  (syringeEdge),
        .snap_cnt     (snap_cnt),
        .snap_edge    (snap_edge),
        .snap_strobe  (snap_strobe)
    );

    assign qualify = snap_strobe & (snap_cnt >= COUNT_W'(MIN_OVERLAP));

    // Next-state: event capture, handshake, missed counting and cooldown.
    always_comb begin
        state_d  = state_q;
        cd_d     = cd_q;
        valid_d  = hit_valid;
        edge_d   = hit_edge;
        count_d  = hit_count;
        missed_d = missed_hits;
        case (state_q)
            ARMED: begin
                if (qualify) begin
                    state_d = PENDING;
                    valid_d = 1'b1;
                    edge_d  = snap_edge;
                    count_d = snap_cnt;
                end
            end
            PENDING: begin
                // A new qualifying frame never replaces the pending event,
                // even when it coincides with the ack.
                if (qualify && missed_hits != 8'hFF)
                    missed_d = missed_hits + 8'd1;
                if (hit_ack) begin
                    valid_d = 1'b0;
                    if (COOLDOWN_FRAMES == 0) begin
                        state_d = ARMED;
                    end else begin
                        state_d = COOLDOWN;
                        cd_d    = CD_LOAD;
                    end
                end
            end
            COOLDOWN: begin
                // The frame whose boundary ends cooldown is still discarded.
                if (startOfFrame) begin
                    cd_d = cd_q - CD_W'(1);
                    if (cd_q == CD_W'(1))
                        state_d = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ARMED;
            cd_q            <= '0;
            hit_valid       <= 1'b0;
            hit_edge        <= '0;
            hit_count       <= '0;
            missed_hits     <= '0;
            cooldown_active <= 1'b0;
        end else begin
            state_q         <= state_d;
            cd_q            <= cd_d;
            hit_valid       <= valid_d;
            hit_edge        <= edge_d;
            hit_count       <= count_d;
            missed_hits     <= missed_d;
            cooldown_active <= (state_d == COOLDOWN);
        end
    end

endmodule

// File: tb/tb_syringe_hit_collector.sv
// Bench for syringe_hit_collector: directed scenarios then random frames,
// every cycle checked against a frame-level behavioural model.
module tb_syringe_hit_collector;

    localparam int MIN = 4;
    localparam int CDF = 2;
    localparam int CW  = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic          startOfFrame, playerDR, syringeDR, hit_ack;
    logic [3:0]    syringeEdge;
    logic          hit_valid, cooldown_active;
    logic [3:0]    hit_edge;
    logic [CW-1:0] hit_count;
    logic [7:0]    missed_hits;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: pixel tally of the current frame, plus the event/cooldown view.
    int         m_cnt;
    logic [3:0] m_edge;
    bit         m_pend;
    int         m_cool;
    int         m_missed;
    logic [3:0] m_hedge;
    int         m_hcnt;

    syringe_hit_collector #(
        .MIN_OVERLAP     (MIN),
        .COOLDOWN_FRAMES (CDF),
        .COUNT_W         (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .playerDR        (playerDR),
        .syringeDR       (syringeDR),
        .syringeEdge     (syringeEdge),
        .hit_valid       (hit_valid),
        .hit_edge        (hit_edge),
        .hit_count       (hit_count),
        .hit_ack         (hit_ack),
        .missed_hits     (missed_hits),
        .cooldown_active (cooldown_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input bit sof, input bit p, input bit s, input logic [3:0] e,
                        input bit ack, input bit rst);
        bit         ov, q;
        int         snap_c;
        logic [3:0] snap_e;
        startOfFrame = sof; playerDR = p; syringeDR = s;
        syringeEdge  = e;   hit_ack  = ack; reset = rst;
        @(posedge clk);
        ov = p & s;
        if (rst) begin
            m_cnt = 0; m_edge = 0; m_pend = 0; m_cool = 0;
            m_missed = 0; m_hedge = 0; m_hcnt = 0;
        end else begin
            q      = sof && (m_cnt >= MIN);
            snap_c = m_cnt;
            snap_e = m_edge;
            if (sof) begin
                m_cnt  = ov ? 1 : 0;
                m_edge = ov ? e : 4'h0;
            end else if (ov) begin
                m_cnt++;
                m_edge |= e;
            end
            if (m_pend) begin
                if (q && m_missed < 255) m_missed++;
                if (ack) begin m_pend = 0; m_cool = CDF; end
            end else if (m_cool > 0) begin
                if (sof) m_cool--;
            end else if (q) begin
                m_pend = 1; m_hedge = snap_e; m_hcnt = snap_c;
            end
        end
        #1;
        chk("hit_valid", hit_valid, m_pend);
        chk("cooldown_active", cooldown_active, m_cool > 0);
        chk("missed_hits", missed_hits, m_missed);
        if (m_pend) begin
            chk("hit_edge", hit_edge, m_hedge);
            chk("hit_count", hit_count, m_hcnt);
        end
    endtask

    task automatic ovl(input logic [3:0] e); step(0, 1, 1, e, 0, 0); endtask
    task automatic idle();                   step(0, 0, 0, 4'h0, 0, 0); endtask
    task automatic sofp();                   step(1, 0, 0, 4'h0, 0, 0); endtask
    task automatic ackc();                   step(0, 0, 0, 4'h0, 1, 0); endtask
    task automatic rstc();                   step(0, 0, 0, 4'h0, 0, 1); endtask

    initial begin
        bit         r_sof, r_p, r_s, r_ack, r_rst;
        logic [3:0] r_e;
        int         len;

        rstc(); rstc();
        chk("rst_valid", hit_valid, 0);
        chk("rst_edge", hit_edge, 0);
        chk("rst_count", hit_count, 0);
        chk("rst_missed", missed_hits, 0);
        chk("rst_cool", cooldown_active, 0);

        // Below threshold: 3 overlap pixels
        sofp();
        repeat (3) ovl(4'h2);
        idle();
        sofp();
        chk("thr_valid", hit_valid, 0);
        chk("thr_missed", missed_hits, 0);

        // Accumulate and report
        ovl(4'h8); ovl(4'h8); ovl(4'h1); ovl(4'h1); ovl(4'h1); ovl(4'h1);
        sofp();
        chk("acc_valid", hit_valid, 1);
        chk("acc_edge", hit_edge, 4'h9);
        chk("acc_count", hit_count, 6);

        // Hold while pending, two missed frames
        repeat (2) begin
            repeat (5) ovl(4'h2);
            sofp();
        end
        chk("hold_edge", hit_edge, 4'h9);
        chk("hold_count", hit_count, 6);
        chk("hold_missed", missed_hits, 2);
        ackc();
        chk("ack_valid", hit_valid, 0);
        chk("ack_cool", cooldown_active, 1);

        // Cooldown swallows two qualifying frames
        repeat (2) begin
            repeat (5) ovl(4'h3);
            sofp();
            chk("cd_valid", hit_valid, 0);
        end
        chk("cd_armed", cooldown_active, 0);
        repeat (5) ovl(4'h3);
        sofp();
        chk("cd3_valid", hit_valid, 1);
        chk("cd3_count", hit_count, 5);
        chk("cd3_missed", missed_hits, 2);

        ackc(); idle(); sofp(); idle(); sofp();
        chk("armed_again", cooldown_active, 0);

        // Boundary pixel belongs to the new frame
        step(1, 1, 1, 4'h4, 0, 0);
        repeat (3) ovl(4'h4);
        idle();
        sofp();
        chk("bnd_valid", hit_valid, 1);
        chk("bnd_count", hit_count, 4);
        chk("bnd_edge", hit_edge, 4'h4);

        // Reset while pending
        repeat (4) ovl(4'h1);
        sofp();
        chk("pre_rst_missed", missed_hits, 3);
        ovl(4'h2); ovl(4'h2);
        rstc();
        chk("mrst_valid", hit_valid, 0);
        chk("mrst_missed", missed_hits, 0);
        chk("mrst_cool", cooldown_active, 0);
        chk("mrst_count", hit_count, 0);
        chk("mrst_edge", hit_edge, 0);
        repeat (4) ovl(4'h1);
        sofp();
        chk("post_rst_valid", hit_valid, 1);
        chk("post_rst_count", hit_count, 4);
        chk("post_rst_edge", hit_edge, 4'h1);
        ackc();

        // Random frames with random acks and rare resets
        for (int f = 0; f < 250; f++) begin
            len = $urandom_range(6, 14);
            for (int c = 0; c < len; c++) begin
                r_sof = (c == 0);
                r_p   = ($urandom % 3) != 0;
                r_s   = ($urandom % 2) != 0;
                r_e   = 4'($urandom);
                r_ack = ($urandom % 5) == 0;
                r_rst = ($urandom % 500) == 0;
                step(r_sof, r_p, r_s, r_e, r_ack, r_rst);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
